weighted_slice_arbiter: RTL and testbench

- Round-robin arbiter sharing one resource among N requesters. Each grant lasts a per-requester programmable time slice.
- A grant ends early when the owner drops its request.
- Sits between requesting masters and the shared resource; gnt drives the resource mux/enable directly.
- Successor to the fixed-slice arbiter: adds weighted slices, early release, owner id and remaining-slice status.

---
 rtl/arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 37 +++
 rtl/weighted_slice_arbiter.sv | 150 +++++++++++++++
 tb/tb_weighted_slice_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the slice arbiters.
//   arb_state_e     - arbiter FSM states (GUARD is only used when the
//                     ARB_GUARD_CYCLE_EN build option is defined)
//   ARB_DEF_N       - default requester count
//   ARB_DEF_SLICE_W - default slice-length field width
//   arb_clamp_slice - maps a zero slice length to one cycle
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } arb_state_e;

    localparam int ARB_DEF_N         = 4;
    localparam int ARB_DEF_SLICE_W   = 4;
    // Widest slice field the clamp helper handles.
    localparam int ARB_MAX_SLICE_W   = 16;

    // A programmed length of 0 still grants one cycle, so a slice can
    // never be empty and the counter never underflows.
    function automatic logic [ARB_MAX_SLICE_W-1:0] arb_clamp_slice(
        input logic [ARB_MAX_SLICE_W-1:0] len
    );
        return (len == '0) ? ARB_MAX_SLICE_W'(1) : len;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
// Searches req starting at (last+1) mod N, wrapping, and returns the first
// set bit. The bit at 'last' itself has the lowest priority.
//   req    [N-1:0]  request vector
//   last   [IW-1:0] index of the previous winner
//   any             some request is set
//   idx    [IW-1:0] winner index (0 when none)
//   onehot [N-1:0]  winner as one-hot (0 when none)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    int j;

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        for (int off = 1; off <= N; off++) begin
            j = (int'(last) + off) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = IW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/weighted_slice_arbiter.sv
// weighted_slice_arbiter: round-robin arbiter with a per-requester time
// slice, early release when the owner drops req, and owner/remaining
// status outputs. gnt is registered and drives the resource mux directly.
//
// Build option ARB_GUARD_CYCLE_EN: when defined, every grant end passes
// through a one-cycle GUARD state with all outputs low (bus turnaround).
//
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          [N-1:0]          request vector, held while wanted
//   slice_len    [N*SLICE_W-1:0]  slice length of requester i at
//                                 [i*SLICE_W +: SLICE_W], 0 acts as 1
//   gnt          [N-1:0]          one-hot grant (registered)
//   gnt_valid                     any gnt bit set
//   gnt_id       [$clog2(N)-1:0]  current owner, 0 when idle
//   slice_remain [SLICE_W-1:0]    cycles left including this one, 0 idle
module weighted_slice_arbiter
    import arb_pkg::*;
#(
    parameter int N       = ARB_DEF_N,
    parameter int SLICE_W = ARB_DEF_SLICE_W,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*SLICE_W-1:0] slice_len,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [IW-1:0]        gnt_id,
    output logic [SLICE_W-1:0]   slice_remain
);

    arb_state_e           state_q, state_d;
    logic [N-1:0]         gnt_q, gnt_d;
    logic [IW-1:0]        id_q, id_d;
    logic [SLICE_W-1:0]   rem_q, rem_d;
    logic [IW-1:0]        last_q, last_d;

    logic                 pick_any;
    logic [IW-1:0]        pick_idx;
    logic [N-1:0]         pick_oh;
    logic [IW-1:0]        pick_last;
    logic [SLICE_W-1:0]   win_raw;
    logic [SLICE_W-1:0]   win_slice;
    logic                 slice_end;

    // While granting, the pointer update to the owner happens on the same
    // edge as the handover, so the picker must already search from the
    // owner rather than from the stale registered pointer.
    assign pick_last = (state_q == GRANT) ? id_q : last_q;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (req),
        .last   (pick_last),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    assign win_raw   = slice_len[pick_idx*SLICE_W +: SLICE_W];
    assign win_slice = SLICE_W'(arb_clamp_slice(ARB_MAX_SLICE_W'(win_raw)));

    // Early release or expiry; both end the grant identically.
    assign slice_end = !req[id_q] || (rem_q == SLICE_W'(1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        rem_d   = rem_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = pick_oh;
                    id_d    = pick_idx;
                    rem_d   = win_slice;
                end
            end
            GRANT: begin
                if (slice_end) begin
                    last_d = id_q;
`ifdef ARB_GUARD_CYCLE_EN
                    state_d = GUARD;
                    gnt_d   = '0;
                    id_d    = '0;
                    rem_d   = '0;
`else
                    if (pick_any) begin
                        // Back-to-back handover, or owner re-grant when it
                        // is the only requester left.
                        gnt_d = pick_oh;
                        id_d  = pick_idx;
                        rem_d = win_slice;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        id_d    = '0;
                        rem_d   = '0;
                    end
`endif
                end else begin
                    rem_d = rem_q - SLICE_W'(1);
                end
            end
`ifdef ARB_GUARD_CYCLE_EN
            GUARD: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = pick_oh;
                    id_d    = pick_idx;
                    rem_d   = win_slice;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = '0;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            rem_q   <= '0;
            last_q  <= IW'(N - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
        end
    end

    assign gnt          = gnt_q;
    assign gnt_valid    = |gnt_q;
    assign gnt_id       = id_q;
    assign slice_remain = rem_q;

endmodule

// File: tb/tb_weighted_slice_arbiter.sv
// tb_weighted_slice_arbiter: directed-vector bench for weighted_slice_arbiter
// (N=4, SLICE_W=4). Outputs are sampled 1 time unit after each rising edge;
// inputs change at the same point so they are picked up on the next edge.
// With ARB_GUARD_CYCLE_EN defined only the guard-cycle sequence is run.
module tb_weighted_slice_arbiter;

    localparam int N       = 4;
    localparam int SLICE_W = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req;
    logic [N*SLICE_W-1:0] slice_len;
    logic [N-1:0]         gnt;
    logic                 gnt_valid;
    logic [1:0]           gnt_id;
    logic [SLICE_W-1:0]   slice_remain;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    weighted_slice_arbiter #(.N(N), .SLICE_W(SLICE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .slice_len    (slice_len),
        .gnt          (gnt),
        .gnt_valid    (gnt_valid),
        .gnt_id       (gnt_id),
        .slice_remain (slice_remain)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                           input logic [3:0] e_rem);
        chk({tag, ".gnt"},   32'(gnt),          32'(e_gnt));
        chk({tag, ".vld"},   32'(gnt_valid),    32'(e_gnt != 4'd0));
        chk({tag, ".id"},    32'(gnt_id),       32'(e_id));
        chk({tag, ".rem"},   32'(slice_remain), 32'(e_rem));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected sequences, one entry per edge.
    logic [3:0] t2_gnt [6] = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010, 4'b0010};
    logic [1:0] t2_id  [6] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1};
    logic [3:0] t2_rem [6] = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
    logic [1:0] t3_id  [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    logic [3:0] t3_rem [10] = '{1, 4, 3, 2, 1, 1, 4, 3, 2, 1};
    logic [3:0] g_gnt  [7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    logic [1:0] g_id   [7] = '{0, 0, 0, 1, 1, 0, 0};
    logic [3:0] g_rem  [7] = '{2, 1, 0, 2, 1, 0, 2};

    initial begin
        rst_n     = 1'b1;
        req       = '0;
        slice_len = {4'd3, 4'd3, 4'd3, 4'd3};
        #2 rst_n  = 1'b0;
        #2;
        chk_all("reset", 4'b0000, 2'd0, 4'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

`ifdef ARB_GUARD_CYCLE_EN
        slice_len = {4'd2, 4'd2, 4'd2, 4'd2};
        req       = 4'b0011;
        for (int i = 0; i < 7; i++) begin
            step();
            chk_all($sformatf("guard[%0d]", i), g_gnt[i], g_id[i], g_rem[i]);
        end
`else
        // Single requester: continuous grant with slice re-load.
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_all($sformatf("solo[%0d]", i), 4'b0001, 2'd0, 4'(3 - (i % 3)));
        end
        req = 4'b0000;
        step();
        chk_all("solo_idle", 4'b0000, 2'd0, 4'd0);

        // Two requesters alternate with no gap cycles.
        slice_len = {4'd2, 4'd2, 4'd2, 4'd2};
        req       = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_all($sformatf("alt[%0d]", i), t2_gnt[i], t2_id[i], t2_rem[i]);
        end
        req = 4'b0000;
        step();
        chk_all("alt_idle", 4'b0000, 2'd0, 4'd0);

        // Weighted slices 1 and 4.
        slice_len = {4'd0, 4'd0, 4'd4, 4'd1};
        req       = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_all($sformatf("wt[%0d]", i), (t3_id[i] == 2'd0) ? 4'b0001 : 4'b0010,
                    t3_id[i], t3_rem[i]);
        end
        req = 4'b0000;
        step();
        chk_all("wt_idle", 4'b0000, 2'd0, 4'd0);

        // Early release hands over to a pending requester; slice_len
        // changes mid-slice are ignored.
        slice_len = {4'd3, 4'd5, 4'd0, 4'd0};
        req       = 4'b0100;
        step();
        chk_all("early0", 4'b0100, 2'd2, 4'd5);
        step();
        chk_all("early1", 4'b0100, 2'd2, 4'd4);
        req = 4'b1000;
        step();
        chk_all("handover", 4'b1000, 2'd3, 4'd3);
        slice_len = {4'd7, 4'd5, 4'd0, 4'd0};
        step();
        chk_all("midchg", 4'b1000, 2'd3, 4'd2);
        req = 4'b0000;
        step();
        chk_all("early_idle", 4'b0000, 2'd0, 4'd0);

        // Zero slices act as one cycle; async reset mid-rotation.
        slice_len = '0;
        req       = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all($sformatf("rot[%0d]", i), 4'(1 << (i % 4)), 2'(i % 4), 4'd1);
        end
        step();
        chk_all("rot_pre", 4'b0010, 2'd1, 4'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("rst_mid", 4'b0000, 2'd0, 4'd0);
        #2 rst_n = 1'b1;
        step();
        chk_all("rst_first", 4'b0001, 2'd0, 4'd1);
        step();
        chk_all("rst_next", 4'b0010, 2'd1, 4'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
